mdu_iter: RTL and testbench

- Iterative RV M-extension multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the src1/src2 operands read from the register file, together with the destination index rd.
- Runs a shift-add multiply or a restoring divide over XLEN cycles.
- Returns the result and rd on a valid/ready writeback handshake; the writeback path drives reg_in/rd/reg_wen back into the register file.

---
 rtl/mdu_iter.sv | 207 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Purpose  : Iterative RV M-extension unit: shift-add multiply, restoring
//            divide, XLEN iterations, valid/ready writeback.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  c_int_min = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(XLEN-1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_busy;

    // ---------------- operand conditioning at accept ----------------
    logic            w_accept;
    logic            w_s1_neg;
    logic            w_s2_neg;
    logic            w_div_signed;
    logic            w_abs1_en;
    logic            w_abs2_en;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_sign;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic [XLEN-1:0] w_special_res;

    assign w_accept     = in_valid && r_in_ready;
    assign w_s1_neg     = src1[XLEN-1];
    assign w_s2_neg     = src2[XLEN-1];
    assign w_div_signed = op[2] && !op[0];
    assign w_abs1_en    = (op == 3'd1) || (op == 3'd2) || w_div_signed;
    assign w_abs2_en    = (op == 3'd1) || w_div_signed;
    assign w_mag1       = (w_abs1_en && w_s1_neg) ? (-src1) : src1;
    assign w_mag2       = (w_abs2_en && w_s2_neg) ? (-src2) : src2;

    always_comb begin
        w_sign = 1'b0;
        case (op)
            3'd1:    w_sign = w_s1_neg ^ w_s2_neg;
            3'd2:    w_sign = w_s1_neg;
            3'd4:    w_sign = w_s1_neg ^ w_s2_neg;
            3'd6:    w_sign = w_s1_neg;
            default: w_sign = 1'b0;
        endcase
    end

    assign w_div_zero = op[2] && (src2 == '0);
    assign w_div_ovf  = w_div_signed && (src1 == c_int_min) && (src2 == '1);

    // op[1] distinguishes remainder from quotient
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op[1] ? src1 : '1;
        end else begin
            w_special_res = op[1] ? '0 : src1;
        end
    end

    // ---------------- multiply iteration ----------------
    logic [2*XLEN-1:0] w_addend;
    logic [2*XLEN-1:0] w_mul_acc;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;

    assign w_addend   = {{XLEN{1'b0}}, r_a} << r_cnt;
    assign w_mul_acc  = r_b[0] ? (r_acc + w_addend) : r_acc;
    assign w_prod_fix = r_neg ? (-w_mul_acc) : w_mul_acc;
    assign w_mul_res  = (r_op == 3'd0) ? w_prod_fix[XLEN-1:0]
                                       : w_prod_fix[2*XLEN-1:XLEN];

    // ---------------- divide iteration ----------------
    // r_acc holds {rem, quo}; rem stays below the divisor so XLEN bits suffice
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN+1:0]   w_trial;
    logic              w_ge;
    logic [2*XLEN-1:0] w_div_acc;
    logic [XLEN-1:0]   w_div_sel;
    logic [XLEN-1:0]   w_div_res;

    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_trial   = {1'b0, w_rem_sh} - {2'b00, r_b};
    assign w_ge      = !w_trial[XLEN+1];
    assign w_div_acc = {(w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_ge};
    assign w_div_sel = r_op[1] ? w_div_acc[2*XLEN-1:XLEN] : w_div_acc[XLEN-1:0];
    assign w_div_res = r_neg ? (-w_div_sel) : w_div_sel;

    logic w_last;
    assign w_last = (r_cnt == c_last);

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_neg       <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_rd       <= rd_in;
                        r_a        <= w_mag1;
                        r_b        <= w_mag2;
                        r_neg      <= w_sign;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (!op[2]) begin
                            r_acc   <= '0;
                            r_state <= S_MUL;
                        end else if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_mag1};
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_mul_res;
                        r_state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_acc;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_div_res;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign rd_out    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Purpose  : Directed scoreboard bench for mdu_iter (XLEN=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mdu_iter #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic drive(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r);
        wait_ready();
        op = o; src1 = a; src2 = b; rd_in = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1 = '0; src2 = '0; rd_in = '0;
    endtask

    task automatic start(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r, input logic [63:0] exp_res, input int exp_lat);
        exp_t e;
        e.res = exp_res; e.rd = r; e.lat = exp_lat;
        sb.push_back(e);
        drive(o, a, b, r);
    endtask

    task automatic collect(input string tag, input int hold);
        int   n = 0;
        exp_t e;
        logic [63:0] res_q;
        logic [4:0]  rd_q;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 64'(n), 64'(e.lat));
        check({tag, "_res"}, result, e.res);
        check({tag, "_rd"}, {59'd0, rd_out}, {59'd0, e.rd});
        res_q = result;
        rd_q  = rd_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_hold_res"}, result, res_q);
            check({tag, "_hold_rd"}, {59'd0, rd_out}, {59'd0, rd_q});
            check({tag, "_hold_inrdy"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_idle_inrdy"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; src1 = '0; src2 = '0; rd_in = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_rd", {59'd0, rd_out}, 64'd0);

        start(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        check("mul_busy", {63'd0, busy}, 64'd1);
        collect("mul", 0);
        start(3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        collect("mulh", 0);
        start(3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd7, 64'd2, 65);
        collect("mulhu", 0);
        start(3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        collect("mulhsu", 0);
        start(3'd3, 64'h1_0000_0001, 64'h1_0000_0000, 5'd1, 64'd1, 65);
        collect("mulhu_big", 0);

        start(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        collect("div", 0);
        start(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        collect("rem", 0);
        start(3'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'h7FFF_FFFF_FFFF_FFFC, 65);
        collect("divu", 0);
        start(3'd7, 64'd100, 64'd7, 5'd0, 64'd2, 65);
        collect("remu", 0);

        start(3'd4, 64'd5, 64'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        collect("div_zero", 0);
        start(3'd7, 64'd5, 64'd0, 5'd14, 64'd5, 1);
        collect("remu_zero", 0);
        start(3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15,
              64'h8000_0000_0000_0000, 1);
        collect("div_ovf", 0);
        start(3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 64'd0, 1);
        collect("rem_ovf", 0);

        out_ready = 1'b0;
        start(3'd5, 64'd1000, 64'd10, 5'd17, 64'd100, 65);
        collect("bp", 10);
        start(3'd0, 64'd9, 64'd9, 5'd18, 64'd81, 65);
        collect("after_bp", 0);

        drive(3'd5, 64'd12345, 64'd7, 5'd19);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_result", result, 64'd0);
        start(3'd0, 64'd6, 64'd7, 5'd20, 64'd42, 65);
        collect("post_abort", 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
